// File: rtl/salamander_loader_pkg.sv
// salamander_loader_pkg: shared constants and types for the ROM loader.
//   ROM_INDEX_DEFAULT : ioctl_index value treated as ROM data by default
//   BYTE_ADDR_W       : usable byte address width (8 MiB window)
//   WORD_ADDR_W       : SDRAM 16-bit word address width
//   fifo_entry_t      : one queued SDRAM write (22-bit word address + 16-bit data)
//   wr_state_t        : SDRAM write handshake FSM states
package salamander_loader_pkg;

    localparam logic [15:0] ROM_INDEX_DEFAULT = 16'h0000;
    localparam int unsigned BYTE_ADDR_W       = 23;
    localparam int unsigned WORD_ADDR_W       = 22;
    localparam int unsigned WORD_W            = 16;
    localparam int unsigned ENTRY_W           = WORD_ADDR_W + WORD_W;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]      data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StGap  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/salamander_loader_fifo.sv
// salamander_loader_fifo: DEPTH x 38-bit word FIFO between byte pairing and the
// SDRAM write FSM. Pointers wrap modulo DEPTH (power of two). A push into a full
// FIFO is dropped (push_ok low) and leaves the contents untouched; push and pop
// in the same cycle both complete.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_entry   : write request and entry
//   push_ok            : push actually stored this cycle
//   pop                : remove head entry (ignored when empty)
//   head               : entry at the read pointer
//   count, full, empty : occupancy status
module salamander_loader_fifo
    import salamander_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fifo_entry_t   push_entry,
    output logic          push_ok,
    input  logic          pop,
    output fifo_entry_t   head,
    output logic [PTR_W:0] count,
    output logic          full,
    output logic          empty
);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             pop_ok;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/salamander_rom_loader.sv
// salamander_rom_loader: pairs HPS ioctl download bytes into 16-bit words and
// writes them to SDRAM through a small FIFO and a REQ/ACK handshake.
// Optional feature: define SALAMANDER_LOADER_CHKSUM_EN to add o_CHKSUM, the
// 16-bit wrapping sum of every stored byte of the current download.
// Ports:
//   i_EMU_MCLK, i_EMU_INITRST_n : clock, asynchronous active-low reset
//   i_IOCTL_*                   : HPS download window, index, byte address/data, strobe
//   o_IOCTL_WAIT                : backpressure, high at FIFO count >= FIFO_DEPTH-1
//   o_SDRAM_REQ/ADDR/DATA       : word write request, held until i_SDRAM_ACK
//   i_SDRAM_ACK                 : one-cycle write-accepted pulse
//   o_BUSY, o_DONE              : download/write activity and completion
//   o_OVF                       : sticky byte-dropped flag
//   o_CHKSUM                    : byte checksum (SALAMANDER_LOADER_CHKSUM_EN only)
module salamander_rom_loader
    import salamander_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] ROM_INDEX  = ROM_INDEX_DEFAULT
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_INITRST_n,
    input  logic        i_IOCTL_DOWNLOAD,
    input  logic [15:0] i_IOCTL_INDEX,
    input  logic [26:0] i_IOCTL_ADDR,
    input  logic [7:0]  i_IOCTL_DATA,
    input  logic        i_IOCTL_WR,
    output logic        o_IOCTL_WAIT,
    output logic        o_SDRAM_REQ,
    output logic [21:0] o_SDRAM_ADDR,
    output logic [15:0] o_SDRAM_DATA,
    input  logic        i_SDRAM_ACK,
    output logic        o_BUSY,
    output logic        o_DONE,
    output logic        o_OVF
`ifdef SALAMANDER_LOADER_CHKSUM_EN
    ,
    output logic [15:0] o_CHKSUM
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Download window edges
    logic dl_q;
    logic dl_rise;
    logic dl_fall;

    assign dl_rise = i_IOCTL_DOWNLOAD & ~dl_q;
    assign dl_fall = dl_q & ~i_IOCTL_DOWNLOAD;

    // Byte acceptance and pairing
    logic                   byte_accept;
    logic                   addr_oor;
    logic                   byte_take;
    logic                   odd_push;
    logic                   even_take;
    logic                   flush_push;
    logic                   held_match;
    logic [WORD_ADDR_W-1:0] byte_waddr;

    logic                   held_valid_q;
    logic [7:0]             held_byte_q;
    logic [WORD_ADDR_W-1:0] held_waddr_q;

    assign byte_accept = i_IOCTL_WR & i_IOCTL_DOWNLOAD & (i_IOCTL_INDEX == ROM_INDEX);
    assign addr_oor    = |i_IOCTL_ADDR[26:BYTE_ADDR_W];
    assign byte_take   = byte_accept & ~addr_oor;
    assign byte_waddr  = i_IOCTL_ADDR[BYTE_ADDR_W-1:1];
    assign odd_push    = byte_take & i_IOCTL_ADDR[0];
    assign even_take   = byte_take & ~i_IOCTL_ADDR[0];
    assign held_match  = held_valid_q & (held_waddr_q == byte_waddr);
    // A fall can never coincide with an accepted byte, so both pushes share one port.
    assign flush_push  = dl_fall & held_valid_q;

    // FIFO interface
    logic             push;
    logic             push_ok;
    fifo_entry_t      push_entry;
    logic             pop;
    fifo_entry_t      head;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    logic             fifo_full;
    logic             fifo_empty;

    assign push = odd_push | flush_push;

    always_comb begin
        push_entry = '0;
        if (flush_push) begin
            push_entry.addr = held_waddr_q;
            push_entry.data = {held_byte_q, 8'hFF};
        end else begin
            push_entry.addr = byte_waddr;
            push_entry.data = {(held_match ? held_byte_q : 8'h00), i_IOCTL_DATA};
        end
    end

    salamander_loader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (i_EMU_MCLK),
        .rst_n      (i_EMU_INITRST_n),
        .push       (push),
        .push_entry (push_entry),
        .push_ok    (push_ok),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Write FSM
    wr_state_t state_q;
    logic      req_q;
    logic [WORD_ADDR_W-1:0] sdram_addr_q;
    logic [WORD_W-1:0]      sdram_data_q;

    // Entry stays at the FIFO head until ACK, so push and pop never race on it.
    assign pop = (state_q == StReq) & i_SDRAM_ACK;

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            sdram_addr_q <= '0;
            sdram_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        sdram_addr_q <= head.addr;
                        sdram_data_q <= head.data;
                        req_q        <= 1'b1;
                        state_q      <= StReq;
                    end
                end
                StReq: begin
                    if (i_SDRAM_ACK) begin
                        req_q   <= 1'b0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Status
    logic busy_raw;
    logic drop_event;
    logic wait_q;
    logic ovf_q;
    logic done_q;
    logic armed_q;

    assign busy_raw   = i_IOCTL_DOWNLOAD | ~fifo_empty | (state_q != StIdle) | held_valid_q;
    assign drop_event = (byte_accept & addr_oor) | (push & fifo_full);
    // Wait tracks the post-edge count so it never lags a push by a cycle.
    assign count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(pop & ~fifo_empty);

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            dl_q         <= 1'b0;
            held_valid_q <= 1'b0;
            held_byte_q  <= '0;
            held_waddr_q <= '0;
            wait_q       <= 1'b0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            dl_q   <= i_IOCTL_DOWNLOAD;
            wait_q <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
            ovf_q  <= (ovf_q & ~dl_rise) | drop_event;

            if (even_take) begin
                held_valid_q <= 1'b1;
                held_byte_q  <= i_IOCTL_DATA;
                held_waddr_q <= byte_waddr;
            end else if ((odd_push & held_match) | flush_push) begin
                held_valid_q <= 1'b0;
            end

            if (dl_rise) begin
                done_q  <= 1'b0;
                armed_q <= 1'b0;
            end else if ((armed_q | dl_fall) & ~busy_raw) begin
                done_q  <= 1'b1;
                armed_q <= 1'b0;
            end else if (dl_fall) begin
                armed_q <= 1'b1;
            end
        end
    end

`ifdef SALAMANDER_LOADER_CHKSUM_EN
    logic [15:0] chksum_q;

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            chksum_q <= '0;
        end else begin
            chksum_q <= (dl_rise ? 16'h0000 : chksum_q)
                      + (byte_take ? {8'h00, i_IOCTL_DATA} : 16'h0000);
        end
    end

    assign o_CHKSUM = chksum_q;
`endif

    assign o_IOCTL_WAIT = wait_q;
    assign o_SDRAM_REQ  = req_q;
    assign o_SDRAM_ADDR = sdram_addr_q;
    assign o_SDRAM_DATA = sdram_data_q;
    // Gate with reset so the download input cannot show through while held in reset.
    assign o_BUSY       = i_EMU_INITRST_n & busy_raw;
    assign o_DONE       = done_q;
    assign o_OVF        = ovf_q;

endmodule

// File: tb/tb_salamander_rom_loader.sv
`timescale 1ns/1ps
module tb_salamander_rom_loader;

    localparam int unsigned DEPTH   = 4;
    localparam logic [15:0] ROM_IDX = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dl = 1'b0;
    logic [15:0] idx = '0;
    logic [26:0] addr = '0;
    logic [7:0]  data = '0;
    logic        wr = 1'b0;
    logic        ack = 1'b0;
    logic        io_wait;
    logic        req;
    logic [21:0] s_addr;
    logic [15:0] s_data;
    logic        busy;
    logic        done;
    logic        ovf;
`ifdef SALAMANDER_LOADER_CHKSUM_EN
    logic [15:0] chksum;
`endif

    always #5 clk = ~clk;

    salamander_rom_loader #(
        .FIFO_DEPTH (DEPTH),
        .ROM_INDEX  (ROM_IDX)
    ) dut (
        .i_EMU_MCLK       (clk),
        .i_EMU_INITRST_n  (rst_n),
        .i_IOCTL_DOWNLOAD (dl),
        .i_IOCTL_INDEX    (idx),
        .i_IOCTL_ADDR     (addr),
        .i_IOCTL_DATA     (data),
        .i_IOCTL_WR       (wr),
        .o_IOCTL_WAIT     (io_wait),
        .o_SDRAM_REQ      (req),
        .o_SDRAM_ADDR     (s_addr),
        .o_SDRAM_DATA     (s_data),
        .i_SDRAM_ACK      (ack),
        .o_BUSY           (busy),
        .o_DONE           (done),
        .o_OVF            (ovf)
`ifdef SALAMANDER_LOADER_CHKSUM_EN
        ,
        .o_CHKSUM         (chksum)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: words the SDRAM must see, in order, as {addr, data}
    logic [37:0] exp_q[$];
    bit          h_valid = 1'b0;
    logic [7:0]  h_byte = '0;
    logic [21:0] h_waddr = '0;
    bit          ovf_exp = 1'b0;
    int          n_words_exp = 0;

    task automatic model_push(input logic [21:0] w, input logic [15:0] d);
        // With no acks outstanding the model queue size equals FIFO occupancy.
        if (exp_q.size() >= DEPTH) begin
            ovf_exp = 1'b1;
        end else begin
            exp_q.push_back({w, d});
            n_words_exp++;
        end
    endtask

    task automatic model_byte(input logic [26:0] a, input logic [7:0] d, input logic [15:0] ix);
        logic [21:0] w;
        logic [7:0]  hi;
        if (ix != ROM_IDX) return;
        if (a >= 27'h80_0000) begin
            ovf_exp = 1'b1;
            return;
        end
        w = 22'(a >> 1);
        if ((a % 2) == 0) begin
            h_valid = 1'b1;
            h_byte  = d;
            h_waddr = w;
        end else begin
            hi = (h_valid && h_waddr == w) ? h_byte : 8'h00;
            if (h_valid && h_waddr == w) h_valid = 1'b0;
            model_push(w, {hi, d});
        end
    endtask

    // SDRAM responder and scoreboard
    bit          ack_en = 1'b0;
    bit          stray_en = 1'b0;
    bit          rand_dly = 1'b0;
    int          ack_dly = 0;
    int          req_cyc = 0;
    int          n_writes = 0;
    int          n_req_rise = 0;
    logic        req_prev = 1'b0;
    logic [21:0] first_addr;
    logic [15:0] first_data;
    logic [21:0] last_addr = '0;
    logic [15:0] last_data = '0;
    logic [37:0] want;

    always @(negedge clk) begin
        if (!rst_n) begin
            ack      = 1'b0;
            req_cyc  = 0;
            req_prev = 1'b0;
        end else begin
            if (req && !req_prev) n_req_rise++;
            req_prev = req;
            if (ack) begin
                ack = 1'b0;
            end else if (req) begin
                if (req_cyc == 0) begin
                    first_addr = s_addr;
                    first_data = s_data;
                end
                if (ack_en && req_cyc >= ack_dly) begin
                    check("req_stable", 64'({s_addr, s_data}), 64'({first_addr, first_data}));
                    check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        check("write_addr", 64'(s_addr), 64'(want[37:16]));
                        check("write_data", 64'(s_data), 64'(want[15:0]));
                    end
                    last_addr = s_addr;
                    last_data = s_data;
                    n_writes++;
                    ack     = 1'b1;
                    req_cyc = 0;
                    if (rand_dly) ack_dly = $urandom_range(0, 4);
                end else begin
                    req_cyc++;
                end
            end else begin
                req_cyc = 0;
                // Stray ACK while no request is open must be ignored.
                if (stray_en && $urandom_range(0, 7) == 0) ack = 1'b1;
            end
        end
    end

    // Driver
    task automatic put_byte(input logic [26:0] a, input logic [7:0] d, input logic [15:0] ix,
                            input bit honor);
        int budget;
        budget = 400;
        @(negedge clk);
        while (honor && io_wait && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("wait_timeout", 64'(io_wait), 64'd0);
        wr   = 1'b1;
        addr = a;
        data = d;
        idx  = ix;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic send(input logic [26:0] a, input logic [7:0] d, input logic [15:0] ix,
                        input bit honor);
        model_byte(a, d, ix);
        put_byte(a, d, ix, honor);
    endtask

    task automatic start_dl();
        @(negedge clk);
        dl      = 1'b1;
        ovf_exp = 1'b0;
        h_valid = 1'b0;
        @(negedge clk);
        check("rise_done_clear", 64'(done), 64'd0);
        check("rise_ovf_clear", 64'(ovf), 64'd0);
        check("busy_in_window", 64'(busy), 64'd1);
    endtask

    task automatic end_dl();
        @(negedge clk);
        dl = 1'b0;
        if (h_valid) begin
            h_valid = 1'b0;
            model_push(h_waddr, {h_byte, 8'hFF});
        end
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = 3000;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_ovf"}, 64'(ovf), 64'(ovf_exp));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_nwrites"}, 64'(n_writes), 64'(n_words_exp));
    endtask

    int          r;
    int          base;
    int          rises;
    logic [21:0] w;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req", 64'(req), 64'd0);
        check("rst_wait", 64'(io_wait), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single pair, ACK three cycles after REQ
        ack_en  = 1'b1;
        ack_dly = 3;
        base    = n_writes;
        start_dl();
        send(27'h0, 8'h12, ROM_IDX, 1'b1);
        send(27'h1, 8'h34, ROM_IDX, 1'b1);
        end_dl();
        wait_done("pair");
        check("pair_count", 64'(n_writes - base), 64'd1);
        check("pair_addr", 64'(last_addr), 64'h0);
        check("pair_data", 64'(last_data), 64'h1234);

        // Lone even byte flushed with 0xFF low byte
        start_dl();
        send(27'h100, 8'hAB, ROM_IDX, 1'b1);
        end_dl();
        wait_done("flush");
        check("flush_addr", 64'(last_addr), 64'h80);
        check("flush_data", 64'(last_data), 64'hABFF);

        // Out-of-range address sets OVF; wrong index is silently ignored
        base = n_writes;
        start_dl();
        send(27'h80_0000, 8'h55, ROM_IDX, 1'b1);
        end_dl();
        wait_done("oor");
        start_dl();
        send(27'h2, 8'h77, 16'h0001, 1'b1);
        send(27'h3, 8'h78, 16'h0001, 1'b1);
        end_dl();
        wait_done("badidx");
        check("drop_nwrites", 64'(n_writes - base), 64'd0);

        // Backpressure: stall SDRAM, stream 8 pairs, then release
        ack_en  = 1'b0;
        ack_dly = 1;
        base    = n_writes;
        start_dl();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(27'(2 * (16 + i)), 8'(8'h40 + i), ROM_IDX, 1'b1);
                    send(27'(2 * (16 + i) + 1), 8'(8'hC0 + i), ROM_IDX, 1'b1);
                end
            end
            begin
                repeat (40) @(negedge clk);
                check("bp_wait", 64'(io_wait), 64'd1);
                check("bp_queued", 64'(exp_q.size()), 64'd3);
                check("bp_ovf", 64'(ovf), 64'd0);
                check("bp_nowrite", 64'(n_writes - base), 64'd0);
                ack_en = 1'b1;
            end
        join
        end_dl();
        wait_done("bp");
        check("bp_count", 64'(n_writes - base), 64'd8);

        // FIFO overflow: ignore WAIT and push five words into a stalled FIFO
        ack_en = 1'b0;
        base   = n_writes;
        start_dl();
        for (int i = 0; i < 5; i++) send(27'(2 * i + 1), 8'(i), ROM_IDX, 1'b0);
        check("full_ovf", 64'(ovf), 64'd1);
        check("full_wait", 64'(io_wait), 64'd1);
        ack_en = 1'b1;
        end_dl();
        wait_done("full");
        check("full_count", 64'(n_writes - base), 64'd4);

`ifdef SALAMANDER_LOADER_CHKSUM_EN
        start_dl();
        send(27'h10, 8'hFF, ROM_IDX, 1'b1);
        send(27'h11, 8'h02, ROM_IDX, 1'b1);
        check("chksum", 64'(chksum), 64'h0101);
        end_dl();
        wait_done("chk");
`endif

        // Reset while REQ is high
        ack_en = 1'b0;
        start_dl();
        send(27'h21, 8'h99, ROM_IDX, 1'b1);
        r = 50;
        while (!req && r > 0) begin
            @(negedge clk);
            r--;
        end
        check("rst_mid_req_seen", 64'(req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", 64'(req), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_wait", 64'(io_wait), 64'd0);
        dl = 1'b0;
        exp_q.delete();
        h_valid     = 1'b0;
        ovf_exp     = 1'b0;
        n_words_exp = n_writes;
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        rises  = n_req_rise;
        repeat (10) @(negedge clk);
        check("rst_rel_noreq", 64'(n_req_rise - rises), 64'd0);
        check("rst_rel_busy", 64'(busy), 64'd0);

        // Randomized downloads with random ACK latency and stray ACKs
        stray_en = 1'b1;
        rand_dly = 1'b1;
        for (int round = 0; round < 4; round++) begin
            start_dl();
            for (int k = 0; k < 25; k++) begin
                r = $urandom_range(0, 9);
                w = 22'($urandom);
                if (r <= 5 || r == 9) begin
                    send(27'({w, 1'b0}), 8'($urandom), ROM_IDX, 1'b1);
                    send(27'({w, 1'b1}), 8'($urandom), ROM_IDX, 1'b1);
                end else if (r == 6) begin
                    send(27'({w, 1'b1}), 8'($urandom), ROM_IDX, 1'b1);
                end else if (r == 7) begin
                    send(27'({w, 1'b0}), 8'($urandom),
                         ROM_IDX ^ 16'($urandom_range(1, 16'hFFFF)), 1'b1);
                end else begin
                    send(27'h80_0000 + 27'($urandom_range(0, 27'h77F_FFFF)),
                         8'($urandom), ROM_IDX, 1'b1);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                w = 22'($urandom);
                send(27'({w, 1'b0}), 8'($urandom), ROM_IDX, 1'b1);
            end
            end_dl();
            wait_done("rand");
        end
        stray_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
